rx_word_sm: RTL and testbench

//  Parametrised serial receive controller with integrated deserialiser. Accepts one bit per

---
 rtl/rx_word_sm.sv | 126 ++++++++++++
 tb/tb_rx_word_sm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_sm.sv
// Serial receive controller: packs WORD_W serial bits into a word, writes it to RX memory
// and raises rx_finish once NUM_WORDS words of the frame have been stored.
module rx_word_sm #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic              tx_data,
  input  logic              rx_start,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              rx_finish,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, INC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              ferr_d;
  logic              ready_q, we_q, finish_q, ferr_q;
  logic              accept;
  logic [WORD_W-1:0] shifted;

  assign accept = tx_valid & ((state_q == IDLE) | (state_q == SHIFT));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[WORD_W-2:0], tx_data};
    end else begin : g_lsb_first
      assign shifted = {tx_data, shreg_q[WORD_W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    // Restart overrides every transition and silently drops any partial word.
    if (rx_start) begin
      state_d = IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      shreg_d = '0;
    end else begin
      if (accept) begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_d = SHIFT;
        end
        SHIFT: begin
          if (!tx_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
          end else if (cnt_q == LAST_BIT) begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          cnt_d   = '0;
          state_d = INC;
        end
        INC: begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = IDLE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      shreg_q  <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      finish_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      shreg_q  <= shreg_d;
      ready_q  <= (state_d == IDLE) || (state_d == SHIFT);
      we_q     <= (state_d == WRITE);
      finish_q <= (state_d == DONE);
      ferr_q   <= ferr_d;
    end
  end

  assign rx_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = shreg_q;
  assign rx_finish = finish_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_rx_word_sm.sv
// Bench for rx_word_sm: an 8-bit MSB-first instance and a 16-bit LSB-first instance,
// checked against a frame-level model (word index modulo NUM_WORDS, bit order by position).
module tb_rx_word_sm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tx_valid_a, tx_data_a, rx_start_a;
  logic ready_a, we_a, finish_a, ferr_a;
  logic [1:0] addr_a;
  logic [7:0] wdata_a;
  logic tx_valid_b, tx_data_b, rx_start_b;
  logic ready_b, we_b, finish_b, ferr_b;
  logic [0:0] addr_b;
  logic [15:0] wdata_b;

  rx_word_sm u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a), .tx_data(tx_data_a), .rx_start(rx_start_a),
    .rx_ready(ready_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .rx_finish(finish_a), .frame_err(ferr_a)
  );

  rx_word_sm #(.WORD_W(16), .NUM_WORDS(2), .ADDR_W(1), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_b), .tx_data(tx_data_b), .rx_start(rx_start_b),
    .rx_ready(ready_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .rx_finish(finish_b), .frame_err(ferr_b)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int exp_idx[2] = '{0, 0};
  bit done[2]    = '{1'b0, 1'b0};
  int nwords[2]  = '{4, 2};
  int wbits[2]   = '{8, 16};
  bit msbf[2]    = '{1'b1, 1'b0};
  int we_cnt[2]  = '{0, 0};

  logic        obs_ready, obs_we, obs_finish, obs_ferr;
  logic [1:0]  obs_addr;
  logic [15:0] obs_wdata;
  assign obs_ready  = (sel == 0) ? ready_a  : ready_b;
  assign obs_we     = (sel == 0) ? we_a     : we_b;
  assign obs_finish = (sel == 0) ? finish_a : finish_b;
  assign obs_ferr   = (sel == 0) ? ferr_a   : ferr_b;
  assign obs_addr   = (sel == 0) ? addr_a   : {1'b0, addr_b};
  assign obs_wdata  = (sel == 0) ? {8'h00, wdata_a} : wdata_b;

  always @(negedge clk) begin
    if (we_a === 1'b1) we_cnt[0]++;
    if (we_b === 1'b1) we_cnt[1]++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (dut %0d): observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d);
    if (sel == 0) begin
      tx_valid_a = v;
      tx_data_a  = d;
    end else begin
      tx_valid_b = v;
      tx_data_b  = d;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready",  32'(obs_ready), 32'd1);
    chk("rst_we",     32'(obs_we), 32'd0);
    chk("rst_addr",   32'(obs_addr), 32'd0);
    chk("rst_wdata",  32'(obs_wdata), 32'd0);
    chk("rst_finish", 32'(obs_finish), 32'd0);
    chk("rst_ferr",   32'(obs_ferr), 32'd0);
  endtask

  task automatic start_pulse();
    if (sel == 0) rx_start_a = 1'b1; else rx_start_b = 1'b1;
    tick();
    if (sel == 0) rx_start_a = 1'b0; else rx_start_b = 1'b0;
    drive(1'b0, 1'b0);
    exp_idx[sel] = 0;
    done[sel]    = 1'b0;
    chk("start_finish", 32'(obs_finish), 32'd0);
    chk("start_ready",  32'(obs_ready), 32'd1);
    chk("start_addr",   32'(obs_addr), 32'd0);
    chk("start_ferr",   32'(obs_ferr), 32'd0);
    $display("dut %0d: rx_start pulse", sel);
  endtask

  // Sends one word in the instance's bit order and checks the write timing k+1..k+3.
  task automatic send_word(input logic [15:0] w);
    int W;
    int base;
    logic [15:0] wm;
    W    = wbits[sel];
    wm   = (W == 16) ? w : (w & 16'h00FF);
    base = we_cnt[sel];
    for (int i = 0; i < W; i++) begin
      chk("bit_ready", 32'(obs_ready), 32'd1);
      chk("bit_we",    32'(obs_we), 32'd0);
      chk("bit_ferr",  32'(obs_ferr), 32'd0);
      drive(1'b1, msbf[sel] ? wm[W-1-i] : wm[i]);
      tick();
    end
    drive(1'b0, 1'b0);
    chk("k1_we",    32'(obs_we), 32'd1);
    chk("k1_addr",  32'(obs_addr), 32'(exp_idx[sel]));
    chk("k1_wdata", 32'(obs_wdata), 32'(wm));
    chk("k1_ready", 32'(obs_ready), 32'd0);
    chk("k1_ferr",  32'(obs_ferr), 32'd0);
    tick();
    chk("k2_we",    32'(obs_we), 32'd0);
    chk("k2_ready", 32'(obs_ready), 32'd0);
    tick();
    $display("dut %0d: word %h -> addr %0d", sel, wm, exp_idx[sel]);
    exp_idx[sel] = (exp_idx[sel] + 1) % nwords[sel];
    done[sel]    = (exp_idx[sel] == 0);
    chk("k3_finish", 32'(obs_finish), 32'(done[sel]));
    chk("k3_ready",  32'(obs_ready), 32'(!done[sel]));
    chk("write_count", 32'(we_cnt[sel] - base), 32'd1);
  endtask

  // Sends nb bits (1..W-1) and drops tx_valid: expect a single frame_err pulse and no write.
  task automatic send_abort(input int nb);
    int base;
    base = we_cnt[sel];
    for (int i = 0; i < nb; i++) begin
      drive(1'b1, 1'($urandom));
      tick();
    end
    drive(1'b0, 1'b0);
    tick();
    chk("abort_ferr",  32'(obs_ferr), 32'd1);
    chk("abort_we",    32'(obs_we), 32'd0);
    chk("abort_ready", 32'(obs_ready), 32'd1);
    chk("abort_addr",  32'(obs_addr), 32'(exp_idx[sel]));
    tick();
    chk("abort_ferr_clr", 32'(obs_ferr), 32'd0);
    chk("abort_nowrite",  32'(we_cnt[sel] - base), 32'd0);
    $display("dut %0d: aborted word after %0d bits", sel, nb);
  endtask

  initial begin
    int base;
    logic [7:0] seq_words [4];
    seq_words[0] = 8'h11;
    seq_words[1] = 8'h22;
    seq_words[2] = 8'h33;
    seq_words[3] = 8'h44;
    rst_n = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = 1'b0; rx_start_a = 1'b0;
    tx_valid_b = 1'b0; tx_data_b = 1'b0; rx_start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 0; chk_reset_vals();
    sel = 1; chk_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single word MSB-first, back-to-back bits.
    sel = 0;
    send_word(16'h00A5);
    idle(2);

    // Full frame with idle gaps, then tx_valid in DONE must be ignored.
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      send_word({8'h00, seq_words[i]});
      idle($urandom_range(0, 3));
    end
    base = we_cnt[0];
    repeat (10) begin
      drive(1'b1, 1'($urandom));
      tick();
      chk("done_ready",  32'(obs_ready), 32'd0);
      chk("done_finish", 32'(obs_finish), 32'd1);
      chk("done_we",     32'(obs_we), 32'd0);
    end
    idle(1);
    chk("done_nowrite", 32'(we_cnt[0] - base), 32'd0);

    // Restart from DONE, aborted word, then the retried word lands at the same address.
    start_pulse();
    send_abort(5);
    send_word(16'h003C);

    // Restart mid-word: partial discarded, no frame_err, address back to 0.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom));
      tick();
    end
    drive(1'b1, 1'b1);
    start_pulse();
    idle(1);
    chk("midstart_ferr", 32'(obs_ferr), 32'd0);
    send_word(16'h0096);

    // Async reset mid-word takes effect without a clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom));
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    drive(1'b0, 1'b0);
    exp_idx[0] = 0; done[0] = 1'b0;
    exp_idx[1] = 0; done[1] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    send_word(16'h00F0);

    // Randomised traffic with occasional aborts.
    repeat (25) begin
      if (done[0]) start_pulse();
      if ($urandom_range(0, 3) == 0) send_abort($urandom_range(1, 7));
      send_word(16'($urandom));
      idle($urandom_range(0, 2));
    end

    // 16-bit LSB-first instance, two-word frame.
    sel = 1;
    send_word(16'h1234);
    idle(1);
    send_word(16'hBEEF);
    chk("b_finish", 32'(obs_finish), 32'd1);
    repeat (8) begin
      if (done[1]) start_pulse();
      if ($urandom_range(0, 2) == 0) send_abort($urandom_range(1, 15));
      send_word(16'($urandom));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
